axi_burst_addr_gen: RTL and testbench

AXI_BURST_ADDR_GEN -- requirements
Module: axi_burst_addr_gen

---
 rtl/axi_burst_addr_gen_pkg.sv | 26 ++
 rtl/axi_burst_addr_gen_next_addr.sv | 29 ++
 rtl/axi_burst_addr_gen.sv | 131 +++++++++++++
 tb/tb_axi_burst_addr_gen.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/axi_burst_addr_gen_pkg.sv
// axi_burst_addr_gen_pkg: shared AXI burst types, limits and legality helpers
package axi_burst_addr_gen_pkg;

  typedef enum logic [2:0] {
    SIZE_1B, SIZE_2B, SIZE_4B, SIZE_8B, SIZE_16B, SIZE_32B, SIZE_64B, SIZE_128B
  } axi_burst_size;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } axi_burst_type;

  typedef enum logic {S_IDLE, S_BURST} gen_state_e;

  localparam int AXI_4KB_BOUNDARY = 4096;
  localparam int AXI_4KB_SHIFT    = $clog2(AXI_4KB_BOUNDARY);
  localparam logic [7:0] FIXED_MAX_LEN = 8'd15;

  // WRAP bursts may only carry 2, 4, 8 or 16 beats
  function automatic logic wrap_len_ok(input logic [7:0] len);
    return len inside {8'd1, 8'd3, 8'd7, 8'd15};
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen_next_addr.sv
// axi_next_addr: combinational step from one beat address to the next
module axi_next_addr
  import axi_burst_addr_gen_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [ADDR_WIDTH-1:0] start_i,
  input  logic [2:0]            size_i,
  input  logic [7:0]            len_i,
  input  logic [1:0]            burst_i,
  output logic [ADDR_WIDTH-1:0] next_o
);

  logic [ADDR_WIDTH-1:0] sz, total, boundary, incr, aligned_incr;

  // FIXED holds, WRAP folds back at boundary+total, INCR and reserved step aligned
  always_comb begin
    sz           = ADDR_WIDTH'(1) << size_i;
    total        = (ADDR_WIDTH'(len_i) + ADDR_WIDTH'(1)) << size_i;
    boundary     = start_i & ~(total - ADDR_WIDTH'(1));
    incr         = addr_i + sz;
    aligned_incr = (addr_i & ~(sz - ADDR_WIDTH'(1))) + sz;
    next_o       = (burst_i == BURST_FIXED) ? addr_i :
                   (burst_i == BURST_WRAP)  ? ((incr == boundary + total) ? boundary : incr) :
                                              aligned_incr;
  end

endmodule

// File: rtl/axi_burst_addr_gen.sv
// axi_burst_addr_gen: expands one AXI burst command into per-beat addresses
module axi_burst_addr_gen
  import axi_burst_addr_gen_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [7:0]            cmd_len_i,
  input  logic [2:0]            cmd_size_i,
  input  logic [1:0]            cmd_burst_i,
  input  logic [ID_WIDTH-1:0]   cmd_id_i,
  output logic                  beat_valid_o,
  input  logic                  beat_ready_i,
  output logic [ADDR_WIDTH-1:0] beat_addr_o,
  output logic [7:0]            beat_idx_o,
  output logic                  beat_last_o,
  output logic [ID_WIDTH-1:0]   beat_id_o,
  output logic                  beat_err_o,
  output logic                  busy_o
);

  localparam logic [ADDR_WIDTH-1:0] MAX_BYTES = ADDR_WIDTH'(DATA_WIDTH / 8);

  gen_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, start_q, start_d, next_addr;
  logic [7:0]            len_q, len_d, idx_q, idx_d;
  logic [2:0]            size_q, size_d;
  logic [1:0]            burst_q, burst_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic                  err_q, err_d;
  logic [ADDR_WIDTH-1:0] cmd_sz;
  logic [ADDR_WIDTH:0]   cmd_end;
  logic                  cmd_err;

  axi_next_addr #(.ADDR_WIDTH(ADDR_WIDTH)) u_next (
    .addr_i  (addr_q),
    .start_i (start_q),
    .size_i  (size_q),
    .len_i   (len_q),
    .burst_i (burst_q),
    .next_o  (next_addr)
  );

  // legality of the incoming command; cmd_end is the last byte touched by an INCR burst
  always_comb begin
    cmd_sz  = ADDR_WIDTH'(1) << cmd_size_i;
    cmd_end = {1'b0, cmd_addr_i & ~(cmd_sz - ADDR_WIDTH'(1))}
            + (((ADDR_WIDTH + 1)'(cmd_len_i) + (ADDR_WIDTH + 1)'(1)) << cmd_size_i)
            - (ADDR_WIDTH + 1)'(1);
    cmd_err = (cmd_sz > MAX_BYTES)
           || (cmd_burst_i == BURST_RSVD)
           || (cmd_burst_i == BURST_WRAP && (!wrap_len_ok(cmd_len_i) || |(cmd_addr_i & (cmd_sz - ADDR_WIDTH'(1)))))
           || (cmd_burst_i == BURST_FIXED && cmd_len_i > FIXED_MAX_LEN)
           || (cmd_burst_i == BURST_INCR &&
               cmd_end[ADDR_WIDTH:AXI_4KB_SHIFT] != {1'b0, cmd_addr_i[ADDR_WIDTH-1:AXI_4KB_SHIFT]});
  end

  // next state: capture a command in IDLE, step or finish on each beat handshake
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    start_d = start_q;
    len_d   = len_q;
    size_d  = size_q;
    burst_d = burst_q;
    id_d    = id_q;
    err_d   = err_q;
    idx_d   = idx_q;
    if (state_q == S_IDLE) begin
      if (cmd_valid_i) begin
        state_d = S_BURST;
        addr_d  = cmd_addr_i;
        start_d = cmd_addr_i;
        len_d   = cmd_len_i;
        size_d  = cmd_size_i;
        burst_d = cmd_burst_i;
        id_d    = cmd_id_i;
        err_d   = cmd_err;
        idx_d   = 8'd0;
      end
    end else if (beat_ready_i) begin
      if (idx_q == len_q) begin
        state_d = S_IDLE;
      end else begin
        idx_d  = idx_q + 8'd1;
        addr_d = next_addr;
      end
    end
  end

  // state and captured burst registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      start_q <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      id_q    <= '0;
      err_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      start_q <= start_d;
      len_q   <= len_d;
      size_q  <= size_d;
      burst_q <= burst_d;
      id_q    <= id_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
    end
  end

  assign cmd_ready_o  = rst_ni && state_q == S_IDLE;
  assign beat_valid_o = state_q == S_BURST;
  assign busy_o       = state_q == S_BURST;
  assign beat_addr_o  = addr_q;
  assign beat_idx_o   = idx_q;
  assign beat_last_o  = beat_valid_o && idx_q == len_q;
  assign beat_id_o    = id_q;
  assign beat_err_o   = err_q;

endmodule

// File: tb/tb_axi_burst_addr_gen.sv
// tb_axi_burst_addr_gen: directed vector table plus stall, back-to-back and reset sequences
module tb_axi_burst_addr_gen;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic [31:0] cmd_addr_i = '0;
  logic [7:0]  cmd_len_i = '0;
  logic [2:0]  cmd_size_i = '0;
  logic [1:0]  cmd_burst_i = '0;
  logic [3:0]  cmd_id_i = '0;
  logic        beat_valid_o;
  logic        beat_ready_i = 1'b1;
  logic [31:0] beat_addr_o;
  logic [7:0]  beat_idx_o;
  logic        beat_last_o;
  logic [3:0]  beat_id_o;
  logic        beat_err_o;
  logic        busy_o;

  int total = 0;
  int bad = 0;

  axi_burst_addr_gen #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .ID_WIDTH(4)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .cmd_valid_i  (cmd_valid_i),
    .cmd_ready_o  (cmd_ready_o),
    .cmd_addr_i   (cmd_addr_i),
    .cmd_len_i    (cmd_len_i),
    .cmd_size_i   (cmd_size_i),
    .cmd_burst_i  (cmd_burst_i),
    .cmd_id_i     (cmd_id_i),
    .beat_valid_o (beat_valid_o),
    .beat_ready_i (beat_ready_i),
    .beat_addr_o  (beat_addr_o),
    .beat_idx_o   (beat_idx_o),
    .beat_last_o  (beat_last_o),
    .beat_id_o    (beat_id_o),
    .beat_err_o   (beat_err_o),
    .busy_o       (busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [31:0]      addr;
    logic [7:0]       len;
    logic [2:0]       size;
    logic [1:0]       burst;
    logic [3:0]       id;
    logic [0:3][31:0] exp;
    logic             err;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h want=0x%0h", nm, act, exp);
    end
  endtask

  task automatic send_cmd(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                          input logic [1:0] b, input logic [3:0] id);
    int w = 0;
    while (!cmd_ready_o && w < 20) begin
      @(negedge clk_i);
      w++;
    end
    if (!cmd_ready_o) begin
      total++;
      bad++;
      $display("FAIL cmd_wait got=0 want=1 (cmd_ready_o timeout)");
    end
    cmd_addr_i  = a;
    cmd_len_i   = l;
    cmd_size_i  = s;
    cmd_burst_i = b;
    cmd_id_i    = id;
    cmd_valid_i = 1'b1;
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
  endtask

  task automatic check_beat(input string nm, input logic [31:0] a, input int n, input logic last,
                            input logic [3:0] id, input logic err);
    chk({nm, " valid"}, {31'd0, beat_valid_o}, 32'd1);
    chk({nm, " addr"}, beat_addr_o, a);
    chk({nm, " idx"}, {24'd0, beat_idx_o}, n);
    chk({nm, " last"}, {31'd0, beat_last_o}, {31'd0, last});
    chk({nm, " id"}, {28'd0, beat_id_o}, {28'd0, id});
    chk({nm, " err"}, {31'd0, beat_err_o}, {31'd0, err});
  endtask

  task automatic run_vec(input int i, input vec_t v);
    send_cmd(v.addr, v.len, v.size, v.burst, v.id);
    for (int n = 0; n <= int'(v.len); n++) begin
      check_beat($sformatf("v%0d b%0d", i, n), v.exp[n], n, n == int'(v.len), v.id, v.err);
      @(negedge clk_i);
    end
    chk($sformatf("v%0d idle valid", i), {31'd0, beat_valid_o}, 32'd0);
    chk($sformatf("v%0d idle ready", i), {31'd0, cmd_ready_o}, 32'd1);
  endtask

  initial begin
    vecs[0] = '{32'h1004, 8'd3, 3'd2, 2'd1, 4'd1, {32'h1004, 32'h1008, 32'h100C, 32'h1010}, 1'b0};
    vecs[1] = '{32'h1003, 8'd2, 3'd2, 2'd1, 4'd2, {32'h1003, 32'h1004, 32'h1008, 32'h0}, 1'b0};
    vecs[2] = '{32'h0038, 8'd3, 3'd3, 2'd2, 4'd3, {32'h38, 32'h20, 32'h28, 32'h30}, 1'b0};
    vecs[3] = '{32'h0000, 8'd2, 3'd2, 2'd2, 4'd4, {32'h0, 32'h4, 32'h8, 32'h0}, 1'b1};
    vecs[4] = '{32'h0200, 8'd2, 3'd2, 2'd0, 4'd5, {32'h200, 32'h200, 32'h200, 32'h0}, 1'b0};
    vecs[5] = '{32'h0FF8, 8'd1, 3'd3, 2'd1, 4'd6, {32'hFF8, 32'h1000, 32'h0, 32'h0}, 1'b1};
    vecs[6] = '{32'h0040, 8'd0, 3'd0, 2'd1, 4'd7, {32'h40, 32'h0, 32'h0, 32'h0}, 1'b0};
    vecs[7] = '{32'h0100, 8'd1, 3'd4, 2'd1, 4'd8, {32'h100, 32'h110, 32'h0, 32'h0}, 1'b1};
    vecs[8] = '{32'h0010, 8'd1, 3'd2, 2'd3, 4'd9, {32'h10, 32'h14, 32'h0, 32'h0}, 1'b1};
    vecs[9] = '{32'h0003, 8'd1, 3'd2, 2'd2, 4'hA, {32'h3, 32'h7, 32'h0, 32'h0}, 1'b1};

    #2;
    chk("rst ready", {31'd0, cmd_ready_o}, 32'd0);
    chk("rst valid", {31'd0, beat_valid_o}, 32'd0);
    chk("rst busy", {31'd0, busy_o}, 32'd0);
    chk("rst addr", beat_addr_o, 32'd0);
    chk("rst idx", {24'd0, beat_idx_o}, 32'd0);
    chk("rst last_err", {30'd0, beat_last_o, beat_err_o}, 32'd0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("post rst ready", {31'd0, cmd_ready_o}, 32'd1);

    for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

    send_cmd(32'h80, 8'd16, 3'd2, 2'd0, 4'hB);
    for (int n = 0; n <= 16; n++) begin
      check_beat($sformatf("fix16 b%0d", n), 32'h80, n, n == 16, 4'hB, 1'b1);
      @(negedge clk_i);
    end

    send_cmd(32'h2000, 8'd3, 3'd2, 2'd1, 4'hC);
    check_beat("stall b0", 32'h2000, 0, 1'b0, 4'hC, 1'b0);
    @(negedge clk_i);
    beat_ready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check_beat($sformatf("stall hold%0d", k), 32'h2004, 1, 1'b0, 4'hC, 1'b0);
      @(negedge clk_i);
    end
    beat_ready_i = 1'b1;
    check_beat("stall b1", 32'h2004, 1, 1'b0, 4'hC, 1'b0);
    @(negedge clk_i);
    check_beat("stall b2", 32'h2008, 2, 1'b0, 4'hC, 1'b0);
    @(negedge clk_i);
    check_beat("stall b3", 32'h200C, 3, 1'b1, 4'hC, 1'b0);
    chk("stall b3 ready", {31'd0, cmd_ready_o}, 32'd0);
    cmd_addr_i  = 32'h500;
    cmd_len_i   = 8'd0;
    cmd_size_i  = 3'd2;
    cmd_burst_i = 2'd1;
    cmd_id_i    = 4'hD;
    cmd_valid_i = 1'b1;
    @(negedge clk_i);
    chk("gap valid", {31'd0, beat_valid_o}, 32'd0);
    chk("gap ready", {31'd0, cmd_ready_o}, 32'd1);
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
    check_beat("b2b b0", 32'h500, 0, 1'b1, 4'hD, 1'b0);
    @(negedge clk_i);

    send_cmd(32'h3000, 8'd7, 3'd2, 2'd1, 4'hE);
    @(negedge clk_i);
    @(negedge clk_i);
    check_beat("abort b2", 32'h3008, 2, 1'b0, 4'hE, 1'b0);
    rst_ni = 1'b0;
    #1;
    chk("abort valid", {31'd0, beat_valid_o}, 32'd0);
    chk("abort busy", {31'd0, busy_o}, 32'd0);
    chk("abort ready", {31'd0, cmd_ready_o}, 32'd0);
    chk("abort addr", beat_addr_o, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("release ready", {31'd0, cmd_ready_o}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("release quiet%0d", k), {31'd0, beat_valid_o}, 32'd0);
      @(negedge clk_i);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
